// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard controller for the five-stage core.
// Compares ID source operands against EX/MEM/WB destinations and drives the
// per-stage pipeline register controls, PC hold, ID bypass selects, a
// multi-cycle EX hold FSM and a saturating stall-cycle counter.
module pipe_hazard_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       ID_irom_i,
    input  logic              rs1_use_i,
    input  logic              rs2_use_i,
    input  logic [REG_AW-1:0] EX_wR_i,
    input  logic [REG_AW-1:0] MEM_wR_i,
    input  logic [REG_AW-1:0] WB_wR_i,
    input  logic              EX_rf_we_i,
    input  logic              MEM_rf_we_i,
    input  logic              WB_rf_we_i,
    input  logic              EX_is_load_i,
    input  logic              back_i,
    input  logic              mc_start_i,
    input  logic              perf_clr_i,
    output logic [1:0]        IF_ID_data_ctrl_o,
    output logic [1:0]        ID_EX_data_ctrl_o,
    output logic [1:0]        EX_MEM_data_ctrl_o,
    output logic [1:0]        MEM_WB_data_ctrl_o,
    output logic              keep_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mc_busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [1:0] NORMAL = 2'b00;
    localparam logic [1:0] STOP   = 2'b01;
    localparam logic [1:0] FLUSH  = 2'b10;

    localparam logic       MC_ON   = (MC_LAT > 1);
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              m1_ex, m1_mem, m1_wb;
    logic              m2_ex, m2_mem, m2_wb;
    logic              mc_stall;
    logic              irom_unused;

    // Only the operand fields are decoded; fold the rest so every bit is read.
    assign irom_unused = ^ID_irom_i;

    function automatic logic hit(input logic use_op, input logic we,
                                 input logic [REG_AW-1:0] wr,
                                 input logic [REG_AW-1:0] rs);
        return use_op && we && (wr != '0) && (wr == rs);
    endfunction

    // Operand decode and per-stage match detection
    always_comb begin
        rs1    = ID_irom_i[15 +: REG_AW];
        rs2    = ID_irom_i[20 +: REG_AW];
        m1_ex  = hit(rs1_use_i, EX_rf_we_i,  EX_wR_i,  rs1);
        m1_mem = hit(rs1_use_i, MEM_rf_we_i, MEM_wR_i, rs1);
        m1_wb  = hit(rs1_use_i, WB_rf_we_i,  WB_wR_i,  rs1);
        m2_ex  = hit(rs2_use_i, EX_rf_we_i,  EX_wR_i,  rs2);
        m2_mem = hit(rs2_use_i, MEM_rf_we_i, MEM_wR_i, rs2);
        m2_wb  = hit(rs2_use_i, WB_rf_we_i,  WB_wR_i,  rs2);
        mc_stall = ((state == IDLE) && mc_start_i && MC_ON) ||
                   ((state == BUSY) && (cnt > 4'd1));
    end

    // Prioritised pipeline control and bypass select generation
    always_comb begin
        IF_ID_data_ctrl_o  = NORMAL;
        ID_EX_data_ctrl_o  = NORMAL;
        EX_MEM_data_ctrl_o = NORMAL;
        MEM_WB_data_ctrl_o = NORMAL;
        keep_o             = 1'b0;
        fwd_a_o            = 2'b00;
        fwd_b_o            = 2'b00;
        if (!rst_i) begin
            if (back_i) begin
                IF_ID_data_ctrl_o = FLUSH;
                ID_EX_data_ctrl_o = FLUSH;
            end else if (mc_stall) begin
                IF_ID_data_ctrl_o  = STOP;
                ID_EX_data_ctrl_o  = STOP;
                EX_MEM_data_ctrl_o = FLUSH;
                keep_o             = 1'b1;
            end else if (FWD_EN != 0) begin
                if (EX_is_load_i && (m1_ex || m2_ex)) begin
                    IF_ID_data_ctrl_o = STOP;
                    ID_EX_data_ctrl_o = FLUSH;
                    keep_o            = 1'b1;
                end
            end else if (m1_wb || m2_wb) begin
                IF_ID_data_ctrl_o  = STOP;
                ID_EX_data_ctrl_o  = STOP;
                EX_MEM_data_ctrl_o = STOP;
                MEM_WB_data_ctrl_o = FLUSH;
                keep_o             = 1'b1;
            end else if (m1_mem || m2_mem) begin
                IF_ID_data_ctrl_o  = STOP;
                ID_EX_data_ctrl_o  = STOP;
                EX_MEM_data_ctrl_o = FLUSH;
                keep_o             = 1'b1;
            end else if (m1_ex || m2_ex) begin
                IF_ID_data_ctrl_o = STOP;
                ID_EX_data_ctrl_o = FLUSH;
                keep_o            = 1'b1;
            end

            if (FWD_EN != 0) begin
                if (m1_ex)       fwd_a_o = 2'b01;
                else if (m1_mem) fwd_a_o = 2'b10;
                else if (m1_wb)  fwd_a_o = 2'b11;
                if (m2_ex)       fwd_b_o = 2'b01;
                else if (m2_mem) fwd_b_o = 2'b10;
                else if (m2_wb)  fwd_b_o = 2'b11;
            end
        end
    end

    // Multi-cycle EX hold FSM; a redirect aborts any op in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            mc_busy_o <= 1'b0;
        end else if (back_i) begin
            state     <= IDLE;
            cnt       <= '0;
            mc_busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start_i && MC_ON) begin
                        state     <= BUSY;
                        cnt       <= MC_LOAD;
                        mc_busy_o <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= IDLE;
                        mc_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    mc_busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; clear takes precedence over increment
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
        end else if (keep_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule
